// File: rtl/xor_arb_pkg.sv
// Shared definitions for the shared-XOR arbiter.
//   xor_arb_state_t : FSM encoding (idle, waiting for gate settle, response held)
//   clog2_min1      : ceil(log2(v)) with a floor of 1, used to size index/counter fields
package xor_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } xor_arb_state_t;

  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/xor_arb_rr_pick.sv
// Combinational round-robin picker.
//   req_i        : request vector
//   ptr_i        : highest-priority slot this round
//   gnt_onehot_o : one-hot of the first requesting slot at or after ptr_i (wrapping)
//   gnt_idx_o    : index of that slot
//   any_o        : at least one request present
module xor_arb_rr_pick
  import xor_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_onehot_o,
  output logic [PW-1:0]   gnt_idx_o,
  output logic            any_o
);

  int j;

  // Walk offsets from farthest to nearest so the slot closest to ptr_i wins last.
  always_comb begin
    j            = 0;
    gnt_idx_o    = '0;
    any_o        = 1'b0;
    gnt_onehot_o = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req_i[j]) begin
        gnt_idx_o = PW'(j);
        any_o     = 1'b1;
      end
    end
    if (any_o) gnt_onehot_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/xor_share_arbiter.sv
// Time-multiplexes one shared W-bit XOR gate package among NREQ requesters.
// Round-robin grant, operands held on xor_a/xor_b for SETTLE cycles, then
// xor_y is captured and returned to the granted requester.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high for the same requester; ready never depends on the matching
// valid being held afterwards, and valid may drop at any time before grant.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake, req_ready one-hot, only in idle
//   req_a, req_b        : packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready : response handshake, rsp_valid one-hot to granted slot
//   rsp_y               : captured result, stable while rsp_valid is high
//   xor_a, xor_b, xor_y : pins of the shared XOR package
//   busy                : high whenever not idle
//   err                 : (XOR_ARB_CHECK_EN only) sticky gate-result mismatch
//   dbg_state           : current FSM state
// Optional build macro: XOR_ARB_CHECK_EN adds the reference compare and err.
module xor_share_arbiter
  import xor_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int W      = 4,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_y,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      xor_a,
  output logic [W-1:0]      xor_b,
  input  logic [W-1:0]      xor_y,
  output logic              busy,
`ifdef XOR_ARB_CHECK_EN
  output logic              err,
`endif
  output xor_arb_state_t    dbg_state
);

  localparam int PW = clog2_min1(NREQ);
  localparam int CW = clog2_min1(SETTLE);

  xor_arb_state_t state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  gnt_q, gnt_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic [W-1:0]   rsp_y_q, rsp_y_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           capture;

  logic [NREQ-1:0] pick_onehot;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;

  xor_arb_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_i        (req_valid),
    .ptr_i        (ptr_q),
    .gnt_onehot_o (pick_onehot),
    .gnt_idx_o    (pick_idx),
    .any_o        (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    rsp_y_d   = rsp_y_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      ST_IDLE: begin
        // The picker only selects a slot whose valid is high, so any grant
        // offered here is also a completed handshake.
        if (!rst) begin
          req_ready = pick_onehot;
          if (pick_any) begin
            op_a_d  = req_a[pick_idx*W +: W];
            op_b_d  = req_b[pick_idx*W +: W];
            gnt_d   = pick_idx;
            cnt_d   = CW'(SETTLE - 1);
            state_d = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          rsp_y_d = xor_y;
          capture = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        if (rsp_ready[gnt_q]) begin
          ptr_d   = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      rsp_y_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      rsp_y_q <= rsp_y_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand registers drive the package pins directly and are never cleared
  // between transactions.
  assign xor_a     = op_a_q;
  assign xor_b     = op_b_q;
  assign rsp_y     = rsp_y_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

`ifdef XOR_ARB_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (capture && (xor_y != (op_a_q ^ op_b_q))) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`endif

endmodule

// File: tb/tb_xor_share_arbiter.sv
module tb_xor_share_arbiter;
  import xor_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int EW   = NREQ + W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // ---------------- DUT0: SETTLE=2, combinational gate model ----------------
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_y;
  logic [NREQ-1:0]   rsp_ready = '0;
  logic [W-1:0]      xor_a, xor_b, xor_y;
  logic              busy;
  xor_arb_state_t    dbg_state;
  logic [W-1:0]      stuck0_mask = '0;
`ifdef XOR_ARB_CHECK_EN
  logic err;
`endif

  assign xor_y = (xor_a ^ xor_b) & ~stuck0_mask;

  xor_share_arbiter #(.NREQ(NREQ), .W(W), .SETTLE(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_ready(rsp_ready),
    .xor_a(xor_a), .xor_b(xor_b), .xor_y(xor_y), .busy(busy),
`ifdef XOR_ARB_CHECK_EN
    .err(err),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- DUT1: SETTLE=1, gate with near-full-cycle delay ----------------
  logic [NREQ-1:0]   req_valid1 = '0;
  logic [NREQ*W-1:0] req_a1 = '0;
  logic [NREQ*W-1:0] req_b1 = '0;
  logic [NREQ-1:0]   req_ready1;
  logic [NREQ-1:0]   rsp_valid1;
  logic [W-1:0]      rsp_y1;
  logic [NREQ-1:0]   rsp_ready1 = '0;
  logic [W-1:0]      xor_a1, xor_b1, xor_y1;
  logic              busy1;
  xor_arb_state_t    dbg_state1;
`ifdef XOR_ARB_CHECK_EN
  logic err1;
`endif

  assign #9 xor_y1 = xor_a1 ^ xor_b1;

  xor_share_arbiter #(.NREQ(NREQ), .W(W), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_a(req_a1), .req_b(req_b1), .req_ready(req_ready1),
    .rsp_valid(rsp_valid1), .rsp_y(rsp_y1), .rsp_ready(rsp_ready1),
    .xor_a(xor_a1), .xor_b(xor_b1), .xor_y(xor_y1), .busy(busy1),
`ifdef XOR_ARB_CHECK_EN
    .err(err1),
`endif
    .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard on DUT0 responses ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_word;

  always @(negedge clk) begin
    if (!rst && ((rsp_valid & rsp_ready) != '0)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected got valid=%b y=%h, none expected", rsp_valid, rsp_y);
      end else begin
        exp_word = exp_q.pop_front();
        if ({rsp_valid, rsp_y} !== exp_word) begin
          failures++;
          $display("FAIL rsp_data got valid=%b y=%h, expected valid=%b y=%h",
                   rsp_valid, rsp_y, exp_word[EW-1:W], exp_word[W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_slot(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got %0d responses outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({busy, rsp_valid, req_ready, rsp_y, xor_a, xor_b} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b rv=%b rr=%b y=%h a=%h b=%h, expected all 0",
               busy, rsp_valid, req_ready, rsp_y, xor_a, xor_b);
    end
    checks++;
    if (dbg_state !== ST_IDLE || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got state=%0d busy1=%b, expected IDLE/0", dbg_state, busy1);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    rsp_ready = '1;
    set_slot(1, 4'hA, 4'h6);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL single_req_ready got %b expected 0010", req_ready);
    end
    exp_q.push_back({4'b0010, 4'hC});
    tick();                       // cycle 1
    req_valid = '0;
    #1;
    checks++;
    if (busy !== 1'b1 || xor_a !== 4'hA || xor_b !== 4'h6) begin
      failures++;
      $display("FAIL single_settle got busy=%b a=%h b=%h expected 1/a/6", busy, xor_a, xor_b);
    end
    tick();                       // cycle 2
    #1;
    checks++;
    if (rsp_valid !== '0) begin
      failures++;
      $display("FAIL single_early_rsp got %b expected 0000", rsp_valid);
    end
    tick();                       // cycle 3
    #1;
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_y !== 4'hC) begin
      failures++;
      $display("FAIL single_rsp got valid=%b y=%h expected 0010/c", rsp_valid, rsp_y);
    end
    tick();                       // cycle 4
    #1;
    checks++;
    if (busy !== 1'b0 || xor_a !== 4'hA) begin
      failures++;
      $display("FAIL single_idle got busy=%b xor_a=%h expected 0/a", busy, xor_a);
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] a, b;
    int n, last;
    logic [NREQ-1:0] exp_oh;
    do_reset();
    rsp_ready = '1;
    for (int i = 0; i < NREQ; i++) set_slot(i, W'(i * 3 + 1), W'(4'h9 ^ i));
    for (int g = 0; g < 5; g++) begin
      a = W'((g % 4) * 3 + 1);
      b = W'(4'h9 ^ (g % 4));
      exp_oh = NREQ'(1) << (g % 4);
      exp_q.push_back({exp_oh, a ^ b});
    end
    req_valid = '1;
    last = 0;
    #1;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (req_ready == '0 && n < 16) begin
        tick();
        #1;
        n++;
      end
      exp_oh = NREQ'(1) << (g % 4);
      checks++;
      if (req_ready !== exp_oh) begin
        failures++;
        $display("FAIL rr_grant_%0d got %b expected %b", g, req_ready, exp_oh);
      end
      if (g > 0) begin
        checks++;
        if (cyc - last != 4) begin
          failures++;
          $display("FAIL rr_spacing_%0d got %0d cycles expected 4", g, cyc - last);
        end
      end
      last = cyc;
      tick();
      if (g == 4) req_valid = '0;
      #1;
    end
    drain("rr");
  endtask

  task automatic test_backpressure();
    rsp_ready = '0;
    set_slot(2, 4'h5, 4'h3);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL bp_req_ready got %b expected 0100", req_ready);
    end
    exp_q.push_back({4'b0100, 4'h6});
    tick();
    req_valid = '1;
    tick();
    tick();                       // cycle 3, response up
    rsp_ready = 4'b1011;          // only non-granted slots ready
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_y !== 4'h6 || busy !== 1'b1 || req_ready !== '0) begin
        failures++;
        $display("FAIL bp_hold_%0d got rv=%b y=%h busy=%b rr=%b expected 0100/6/1/0000",
                 k, rsp_valid, rsp_y, busy, req_ready);
      end
      tick();
    end
    rsp_ready = 4'b0100;
    req_valid = '0;
    tick();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got busy=%b expected 0", busy);
    end
    drain("bp");
  endtask

  task automatic test_wrap();
    int n;
    rsp_ready = '1;
    set_slot(3, 4'hF, 4'h1);
    set_slot(0, 4'h2, 4'h7);
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL wrap_first got %b expected 1000", req_ready);
    end
    exp_q.push_back({4'b1000, 4'hE});
    exp_q.push_back({4'b0001, 4'h5});
    tick();
    req_valid = 4'b0001;
    #1;
    n = 0;
    while (req_ready == '0 && n < 16) begin
      tick();
      #1;
      n++;
    end
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_second got %b expected 0001", req_ready);
    end
    tick();
    req_valid = '0;
    drain("wrap");
  endtask

  task automatic test_reset_mid();
    rsp_ready = '1;
    set_slot(1, 4'h3, 4'h3);
    req_valid = 4'b0010;          // ptr is 1 here, slot 1 wins
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (dbg_state !== ST_SETTLE || busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_settle got state=%0d busy=%b expected SETTLE/1", dbg_state, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== '0) begin
      failures++;
      $display("FAIL midrst_idle got busy=%b rv=%b expected 0/0000", busy, rsp_valid);
    end
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_ptr got %b expected 0001", req_ready);
    end
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      checks++;
      if (rsp_valid !== '0) begin
        failures++;
        $display("FAIL midrst_norsp_%0d got %b expected 0000", k, rsp_valid);
      end
    end
  endtask

  task automatic test_random();
    int r, d;
    logic [W-1:0] a, b;
    logic [NREQ-1:0] oh;
    for (int it = 0; it < 8; it++) begin
      r  = $urandom_range(0, NREQ - 1);
      a  = W'($urandom_range(0, 15));
      b  = W'($urandom_range(0, 15));
      d  = $urandom_range(0, 3);
      oh = NREQ'(1) << r;
      set_slot(r, a, b);
      rsp_ready = '0;
      req_valid = oh;
      #1;
      checks++;
      if (req_ready !== oh) begin
        failures++;
        $display("FAIL rand_ready_%0d got %b expected %b", it, req_ready, oh);
      end
      exp_q.push_back({oh, a ^ b});
      tick();
      req_valid = '0;
      tick();
      tick();
      #1;
      checks++;
      if (rsp_valid !== oh) begin
        failures++;
        $display("FAIL rand_latency_%0d got %b expected %b", it, rsp_valid, oh);
      end
      for (int k = 0; k < d; k++) tick();
      rsp_ready = '1;
      tick();
    end
    drain("rand");
  endtask

`ifdef XOR_ARB_CHECK_EN
  task automatic test_check_en();
    do_reset();
    stuck0_mask = 4'b0100;
    rsp_ready = '0;
    set_slot(0, 4'h4, 4'h0);
    req_valid = 4'b0001;
    exp_q.push_back({4'b0001, 4'h0});
    tick();
    req_valid = '0;
    tick();
    #1;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_precapture got %b expected 0", err);
    end
    tick();
    #1;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_capture got %b expected 1", err);
    end
    rsp_ready = '1;
    tick();
    tick();
    #1;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got %b expected 1", err);
    end
    stuck0_mask = '0;
    drain("err");
    do_reset();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_reset got %b expected 0", err);
    end
  endtask
`endif

  task automatic test_settle1();
    rsp_ready1 = '1;
    req_a1[2*W +: W] = 4'h3;
    req_b1[2*W +: W] = 4'h5;
    req_valid1 = 4'b0100;
    #1;
    checks++;
    if (req_ready1 !== 4'b0100) begin
      failures++;
      $display("FAIL s1_ready got %b expected 0100", req_ready1);
    end
    tick();                       // cycle 1
    req_valid1 = '0;
    #1;
    checks++;
    if (rsp_valid1 !== '0) begin
      failures++;
      $display("FAIL s1_early got %b expected 0000", rsp_valid1);
    end
    tick();                       // cycle 2
    #1;
    checks++;
    if (rsp_valid1 !== 4'b0100 || rsp_y1 !== 4'h6) begin
      failures++;
      $display("FAIL s1_rsp got valid=%b y=%h expected 0100/6", rsp_valid1, rsp_y1);
    end
    tick();
    #1;
    checks++;
    if (busy1 !== 1'b0) begin
      failures++;
      $display("FAIL s1_idle got busy=%b expected 0", busy1);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef XOR_ARB_CHECK_EN
    test_check_en();
`endif
    test_settle1();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_queue got %0d outstanding expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
